// File: rtl/diad_pipe_pkg.sv
// Shared types and default widths for diad pipeline stages.
// Used by ctrl_stage_skid and by the stages on either side of it.
package diad_pipe_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 12;
  localparam int SET_W   = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [SET_W-1:0]   set;
  } stage_payload_t;

  function automatic logic [1:0] state_occ(stage_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ST_ONE:  n = 2'd1;
      ST_TWO:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ctrl_stage_slot.sv
// Payload register with load enable.
// One instance is the main slot, one is the skid slot.
module ctrl_stage_slot #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (ld) data_d = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/ctrl_stage_skid.sv
// Valid/ready pipeline stage with two-entry skid buffer,
// flush and saturating stall counter.
module ctrl_stage_skid #(
  parameter int PC_W        = diad_pipe_pkg::PC_W,
  parameter int INSTR_W     = diad_pipe_pkg::INSTR_W,
  parameter int SET_W       = diad_pipe_pkg::SET_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        pc_in,
  input  logic [INSTR_W-1:0]     instr_in,
  input  logic [SET_W-1:0]       instr_set_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        pc_out,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [SET_W-1:0]       instr_set_out,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             occupancy
);

  import diad_pipe_pkg::*;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [SET_W-1:0]   set;
  } pay_t;

  stage_state_t state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic [1:0] occ_q, occ_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic accept;
  logic drain;
  logic m_ld;
  logic s_ld;
  pay_t in_pay;
  pay_t m_d;
  pay_t m_pay;
  pay_t s_pay;

  assign in_pay = '{pc: pc_in, instr: instr_in, set: instr_set_in};
  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    m_ld    = 1'b0;
    s_ld    = 1'b0;
    m_d     = in_pay;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          m_ld    = 1'b1;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          m_ld = 1'b1;
        end else if (accept) begin
          s_ld    = 1'b1;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          m_ld    = 1'b1;
          m_d     = s_pay;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // flush beats everything, including a same-cycle accept
    if (flush) begin
      state_d = ST_EMPTY;
      m_ld    = 1'b0;
      s_ld    = 1'b0;
    end
  end

  always_comb begin
    occ_d       = state_occ(state_d);
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
    stall_d     = stall_q;
    if (out_valid_q && !out_ready && !flush && !(&stall_q))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
      stall_q     <= stall_d;
    end
  end

  ctrl_stage_slot #(.W($bits(pay_t))) u_m (
    .clk (clk),
    .rst (rst),
    .ld  (m_ld),
    .d   (m_d),
    .q   (m_pay)
  );

  ctrl_stage_slot #(.W($bits(pay_t))) u_s (
    .clk (clk),
    .rst (rst),
    .ld  (s_ld),
    .d   (in_pay),
    .q   (s_pay)
  );

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign occupancy     = occ_q;
  assign stall_cnt     = stall_q;
  assign pc_out        = m_pay.pc;
  assign instr_out     = m_pay.instr;
  assign instr_set_out = m_pay.set;

endmodule
